// File: rtl/iq_src_pkg.sv
// Shared types and defaults for the I/Q window source: FSM state encoding,
// default sample width / window length / FIFO depth, and the frame counter width.
package iq_src_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_WIN_LEN    = 256;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int FRAME_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and asynchronous active-low clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module iq_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             push;
  logic             pop;

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  // NOTE: default assignment first so every path assigns count_next (no latch).
  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // NOTE: storage is not reset; the pointers and flags alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/iq_frame_source.sv
// Buffers upstream I/Q pairs and emits WIN_LEN-sample windows framed by alclr/done.
// Define IQ_FRAME_SOURCE_CONT_EN for back-to-back windows while start stays high.
module iq_frame_source
  import iq_src_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   aclr_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_real,
  input  logic [DATA_W-1:0]      in_imag,
  input  logic                   start,
  output logic [DATA_W-1:0]      out_real,
  output logic [DATA_W-1:0]      out_imag,
  output logic                   sample_stb,
  output logic                   alclr,
  output logic                   done,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int                CNT_W    = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIN_LEN - 1);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic [2*DATA_W-1:0] head;

  assign pop      = (state == ST_STREAM) && !fifo_empty;
  assign in_ready = !fifo_full;

  iq_sync_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .wr_en   (in_valid),
    .wr_data ({in_real, in_imag}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_CLEAR;
      ST_CLEAR:  state_next = ST_STREAM;
      ST_STREAM: if (pop && (cnt == LAST_CNT)) state_next = ST_DONE;
      ST_DONE: begin
`ifdef IQ_FRAME_SOURCE_CONT_EN
        state_next = start ? ST_CLEAR : ST_IDLE;
`else
        state_next = ST_IDLE;
`endif
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered decodes of the current state, so each pulse
  // appears in the cycle after the state that produces it.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      out_real   <= '0;
      out_imag   <= '0;
      sample_stb <= 1'b0;
      alclr      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != ST_IDLE);
      alclr      <= (state == ST_CLEAR);
      sample_stb <= pop;
      done       <= (state == ST_DONE);

      if (state == ST_CLEAR)
        cnt <= '0;
      else if (pop)
        cnt <= cnt + 1'b1;

      if (pop)
        {out_real, out_imag} <= head;

      if (state == ST_DONE)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
